// File: rtl/alu_ctrl_fsm.sv
// Multicycle RV32I-subset control unit; drives ALU op/mux selects, consumes Zero.
// Latency: lw 5, sw 4, R/I/jal/lui 4, branch 3 cycles with memory always ready.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady_i is high.
module alu_ctrl_fsm #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] Instr_i,
  input  logic                 Zero_i,
  input  logic                 MemReady_i,
  output logic [3:0]           ALUctrl_o,
  output logic [1:0]           ALUSrcA_o,
  output logic [1:0]           ALUSrcB_o,
  output logic [1:0]           ResultSrc_o,
  output logic [2:0]           ImmSrc_o,
  output logic                 AdrSrc_o,
  output logic                 IRWrite_o,
  output logic                 PCUpdate_o,
  output logic                 MemWrite_o,
  output logic                 RegWrite_o,
  output logic                 Illegal_o,
  output logic [DATAWIDTH-1:0] InstrCount_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t                 state;
  state_t                 state_nxt;
  logic                   retire;
  logic [DATAWIDTH-1:0]   instr_count;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr;

  assign opcode       = Instr_i[6:0];
  assign funct3       = Instr_i[14:12];
  assign funct7b5     = Instr_i[30];
  assign unused_instr = ^{Instr_i[DATAWIDTH-1:31], Instr_i[29:15], Instr_i[11:7]};

  // Shared funct3 decode; alt selects SUB/SRA where the instruction allows it.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Retired-instruction counter, wraps naturally at 2^DATAWIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + DATAWIDTH'(1);
  end

  assign InstrCount_o = instr_count;

  // Next-state decode; retire marks edges that complete an instruction into FETCH.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:    if (MemReady_i) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady_i) state_nxt = S_MEMWB;
      S_MEMWB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        if (MemReady_i) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_nxt = S_ALUWB;
      S_ALUWB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = S_TRAP;
        end
      end
      default:    state_nxt = S_TRAP;
    endcase
  end

  logic ir_write, pc_update, mem_write, reg_write;

  // Per-state output decode; strobes are forced low while reset is asserted.
  always_comb begin
    ALUctrl_o   = ALU_ADD;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    ResultSrc_o = 2'b00;
    AdrSrc_o    = 1'b0;
    ir_write    = 1'b0;
    pc_update   = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        ir_write    = MemReady_i;
        pc_update   = MemReady_i;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
      end
      S_MEMREAD:  AdrSrc_o = 1'b1;
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        reg_write   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc_o  = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA_o = 2'b10;
        ALUctrl_o = alu_decode(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        ALUctrl_o = alu_decode(funct3, funct7b5, 1'b0);
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA_o = 2'b10;
        ALUctrl_o = ALU_SUB;
        if (funct3 == 3'b000)      pc_update = Zero_i;
        else if (funct3 == 3'b001) pc_update = !Zero_i;
      end
      S_JAL: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        pc_update = 1'b1;
      end
      S_LUI: begin
        ALUSrcA_o = 2'b11;
        ALUSrcB_o = 2'b01;
      end
      default: ;
    endcase
  end

  assign IRWrite_o  = ir_write  & rst_n;
  assign PCUpdate_o = pc_update & rst_n;
  assign MemWrite_o = mem_write & rst_n;
  assign RegWrite_o = reg_write & rst_n;
  assign Illegal_o  = (state == S_TRAP) & rst_n;

  // Immediate format follows the opcode alone, independent of state.
  always_comb begin
    case (opcode)
      OP_STORE:  ImmSrc_o = 3'b001;
      OP_BRANCH: ImmSrc_o = 3'b010;
      OP_JAL:    ImmSrc_o = 3'b011;
      OP_LUI:    ImmSrc_o = 3'b100;
      default:   ImmSrc_o = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: each task walks one instruction class.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
// Expected values are hand-derived from the instruction encodings.
module tb_alu_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr_i = 32'h0;
  logic        Zero_i = 1'b0;
  logic        MemReady_i = 1'b0;
  logic [3:0]  ALUctrl_o;
  logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
  logic [2:0]  ImmSrc_o;
  logic        AdrSrc_o, IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o, Illegal_o;
  logic [31:0] InstrCount_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'h0;

  alu_ctrl_fsm #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Instr_i(Instr_i), .Zero_i(Zero_i),
    .MemReady_i(MemReady_i), .ALUctrl_o(ALUctrl_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ResultSrc_o(ResultSrc_o), .ImmSrc_o(ImmSrc_o),
    .AdrSrc_o(AdrSrc_o), .IRWrite_o(IRWrite_o), .PCUpdate_o(PCUpdate_o),
    .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .Illegal_o(Illegal_o),
    .InstrCount_o(InstrCount_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    checks++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemReady_i = 1'b1; Instr_i = 32'h000000B7;
    #3; checks++;
    if ({IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o, Illegal_o} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=00000",
        {IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o, Illegal_o});
    end
    checks++;
    if ({ALUSrcA_o, ALUSrcB_o, ResultSrc_o, AdrSrc_o, ALUctrl_o} !== 11'b00_10_10_0_0000) begin
      errors++; $display("FAIL reset_selects got=%b want=00101000000",
        {ALUSrcA_o, ALUSrcB_o, ResultSrc_o, AdrSrc_o, ALUctrl_o});
    end
    checks++;
    if (InstrCount_o !== 32'h0) begin
      errors++; $display("FAIL reset_count got=%h want=0", InstrCount_o);
    end
    MemReady_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      if (IRWrite_o !== 1'b0 || ALUSrcB_o !== 2'b10 || PCUpdate_o !== 1'b0) begin
        errors++; $display("FAIL fetch_hold cyc=%0d irw=%b pcu=%b srcb=%b want 0 0 10",
          i, IRWrite_o, PCUpdate_o, ALUSrcB_o);
      end
      tick();
    end
    MemReady_i = 1'b1;
    settle();
    if (IRWrite_o !== 1'b1 || PCUpdate_o !== 1'b1) begin
      errors++; $display("FAIL fetch_ready irw=%b pcu=%b want 1 1", IRWrite_o, PCUpdate_o);
    end
    tick();
    settle();
    if (IRWrite_o !== 1'b0 || PCUpdate_o !== 1'b0 || ALUSrcA_o !== 2'b01 || ALUSrcB_o !== 2'b01) begin
      errors++; $display("FAIL decode_after_fetch irw=%b pcu=%b srca=%b srcb=%b want 0 0 01 01",
        IRWrite_o, PCUpdate_o, ALUSrcA_o, ALUSrcB_o);
    end
    // finish the lui: LUI, ALUWB, FETCH
    tick();
    settle();
    if (ALUSrcA_o !== 2'b11 || ALUSrcB_o !== 2'b01 || ImmSrc_o !== 3'b100) begin
      errors++; $display("FAIL lui_state srca=%b srcb=%b imm=%b want 11 01 100",
        ALUSrcA_o, ALUSrcB_o, ImmSrc_o);
    end
    tick(); tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL lui_count got=%h want=%h", InstrCount_o, exp_cnt);
    end
  endtask

  task automatic test_rtype_sub();
    MemReady_i = 1'b1; Instr_i = 32'h40208033;
    tick();
    settle();
    if (ALUSrcA_o !== 2'b01) begin
      errors++; $display("FAIL sub_decode srca=%b want 01", ALUSrcA_o);
    end
    tick();
    settle();
    if (ALUctrl_o !== 4'b0001 || ALUSrcA_o !== 2'b10 || ALUSrcB_o !== 2'b00 || RegWrite_o !== 1'b0) begin
      errors++; $display("FAIL sub_execr alu=%b srca=%b srcb=%b rw=%b want 0001 10 00 0",
        ALUctrl_o, ALUSrcA_o, ALUSrcB_o, RegWrite_o);
    end
    tick();
    settle();
    if (RegWrite_o !== 1'b1 || ResultSrc_o !== 2'b00 || InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL sub_aluwb rw=%b res=%b cnt=%h want 1 00 %h",
        RegWrite_o, ResultSrc_o, InstrCount_o, exp_cnt);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (InstrCount_o !== exp_cnt || ALUSrcB_o !== 2'b10 || IRWrite_o !== 1'b1) begin
      errors++; $display("FAIL sub_retire cnt=%h srcb=%b irw=%b want %h 10 1",
        InstrCount_o, ALUSrcB_o, IRWrite_o, exp_cnt);
    end
  endtask

  task automatic test_itype();
    // addi with bit30 set stays ADD; srai picks SRA
    logic [31:0] instrs [2] = '{32'h40000013, 32'h40005013};
    logic [3:0]  exp_op [2] = '{4'b0000, 4'b1000};
    for (int i = 0; i < 2; i++) begin
      MemReady_i = 1'b1; Instr_i = instrs[i];
      tick(); tick();
      settle();
      if (ALUctrl_o !== exp_op[i] || ALUSrcA_o !== 2'b10 || ALUSrcB_o !== 2'b01) begin
        errors++; $display("FAIL itype_exec%0d alu=%b srca=%b srcb=%b want %b 10 01",
          i, ALUctrl_o, ALUSrcA_o, ALUSrcB_o, exp_op[i]);
      end
      tick(); tick();
      exp_cnt = exp_cnt + 1;
    end
    settle();
    if (InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL itype_count got=%h want=%h", InstrCount_o, exp_cnt);
    end
  endtask

  task automatic test_branch();
    logic [31:0] instrs [3] = '{32'h00208663, 32'h00208663, 32'h00209663};
    logic        zeros  [3] = '{1'b1, 1'b0, 1'b1};
    logic        exp_pc [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      MemReady_i = 1'b1; Instr_i = instrs[i]; Zero_i = ~zeros[i];
      tick();
      settle();
      if (ImmSrc_o !== 3'b010) begin
        errors++; $display("FAIL br_imm%0d got=%b want=010", i, ImmSrc_o);
      end
      tick();
      Zero_i = zeros[i];
      settle();
      if (PCUpdate_o !== exp_pc[i] || ALUctrl_o !== 4'b0001 || ALUSrcA_o !== 2'b10) begin
        errors++; $display("FAIL br_state%0d pcu=%b alu=%b srca=%b want %b 0001 10",
          i, PCUpdate_o, ALUctrl_o, ALUSrcA_o, exp_pc[i]);
      end
      tick();
      exp_cnt = exp_cnt + 1;
      settle();
      if (InstrCount_o !== exp_cnt || ALUSrcB_o !== 2'b10) begin
        errors++; $display("FAIL br_retire%0d cnt=%h srcb=%b want %h 10",
          i, InstrCount_o, ALUSrcB_o, exp_cnt);
      end
    end
    Zero_i = 1'b0;
  endtask

  task automatic test_load_store();
    MemReady_i = 1'b1; Instr_i = 32'h0000A083;
    tick(); tick();
    settle();
    if (ALUSrcA_o !== 2'b10 || ALUSrcB_o !== 2'b01 || AdrSrc_o !== 1'b0) begin
      errors++; $display("FAIL lw_memadr srca=%b srcb=%b adr=%b want 10 01 0",
        ALUSrcA_o, ALUSrcB_o, AdrSrc_o);
    end
    tick();
    MemReady_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (AdrSrc_o !== 1'b1 || RegWrite_o !== 1'b0 || ResultSrc_o !== 2'b00) begin
        errors++; $display("FAIL lw_memread%0d adr=%b rw=%b res=%b want 1 0 00",
          i, AdrSrc_o, RegWrite_o, ResultSrc_o);
      end
      tick();
    end
    MemReady_i = 1'b1;
    tick();
    MemReady_i = 1'b0;
    settle();
    if (ResultSrc_o !== 2'b01 || RegWrite_o !== 1'b1 || InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL lw_memwb res=%b rw=%b cnt=%h want 01 1 %h",
        ResultSrc_o, RegWrite_o, InstrCount_o, exp_cnt);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (RegWrite_o !== 1'b0 || InstrCount_o !== exp_cnt || ALUSrcB_o !== 2'b10) begin
      errors++; $display("FAIL lw_retire rw=%b cnt=%h srcb=%b want 0 %h 10",
        RegWrite_o, InstrCount_o, ALUSrcB_o, exp_cnt);
    end
    // sw with two wait cycles in MEMWRITE
    MemReady_i = 1'b1; Instr_i = 32'h0020A023;
    tick(); tick(); tick();
    MemReady_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      if (MemWrite_o !== 1'b1 || AdrSrc_o !== 1'b1 || ImmSrc_o !== 3'b001) begin
        errors++; $display("FAIL sw_memwrite%0d mw=%b adr=%b imm=%b want 1 1 001",
          i, MemWrite_o, AdrSrc_o, ImmSrc_o);
      end
      tick();
    end
    MemReady_i = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (MemWrite_o !== 1'b0 || InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL sw_retire mw=%b cnt=%h want 0 %h", MemWrite_o, InstrCount_o, exp_cnt);
    end
  endtask

  task automatic test_jal();
    MemReady_i = 1'b1; Instr_i = 32'h0000006F;
    tick(); tick();
    settle();
    if (PCUpdate_o !== 1'b1 || ALUSrcA_o !== 2'b01 || ALUSrcB_o !== 2'b10 || ImmSrc_o !== 3'b011) begin
      errors++; $display("FAIL jal_state pcu=%b srca=%b srcb=%b imm=%b want 1 01 10 011",
        PCUpdate_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o);
    end
    tick();
    settle();
    if (RegWrite_o !== 1'b1 || PCUpdate_o !== 1'b0) begin
      errors++; $display("FAIL jal_aluwb rw=%b pcu=%b want 1 0", RegWrite_o, PCUpdate_o);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL jal_count got=%h want=%h", InstrCount_o, exp_cnt);
    end
  endtask

  task automatic test_trap();
    MemReady_i = 1'b1; Instr_i = 32'h0000007F;
    tick();
    settle();
    if (Illegal_o !== 1'b0 || ImmSrc_o !== 3'b000) begin
      errors++; $display("FAIL trap_decode ill=%b imm=%b want 0 000", Illegal_o, ImmSrc_o);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      Zero_i = i[0];
      settle();
      if (Illegal_o !== 1'b1 || {IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o} !== 4'b0
          || InstrCount_o !== exp_cnt) begin
        errors++; $display("FAIL trap_hold%0d ill=%b strobes=%b cnt=%h want 1 0000 %h", i,
          Illegal_o, {IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o}, InstrCount_o, exp_cnt);
      end
      tick();
    end
    rst_n = 1'b0;
    exp_cnt = 32'h0;
    #2; rst_n = 1'b1;
    MemReady_i = 1'b0;
    settle();
    if (Illegal_o !== 1'b0 || InstrCount_o !== 32'h0 || ALUSrcB_o !== 2'b10) begin
      errors++; $display("FAIL trap_reset ill=%b cnt=%h srcb=%b want 0 0 10",
        Illegal_o, InstrCount_o, ALUSrcB_o);
    end
    tick();
    // undefined branch funct3 traps with no PC update
    MemReady_i = 1'b1; Instr_i = 32'h0020A663; Zero_i = 1'b1;
    tick(); tick();
    settle();
    if (PCUpdate_o !== 1'b0) begin
      errors++; $display("FAIL br_bad_f3 pcu=%b want 0", PCUpdate_o);
    end
    tick();
    settle();
    if (Illegal_o !== 1'b1 || InstrCount_o !== 32'h0) begin
      errors++; $display("FAIL br_bad_trap ill=%b cnt=%h want 1 0", Illegal_o, InstrCount_o);
    end
    Zero_i = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    MemReady_i = 1'b1; Instr_i = 32'h000000B7;
    for (int i = 0; i < 2; i++) begin
      tick(); tick(); tick(); tick();
      exp_cnt = exp_cnt + 1;
    end
    settle();
    if (InstrCount_o !== exp_cnt) begin
      errors++; $display("FAIL b2b_lui_count got=%h want=%h", InstrCount_o, exp_cnt);
    end
    force dut.instr_count = 32'hFFFFFFFF;
    #1;
    release dut.instr_count;
    exp_cnt = 32'hFFFFFFFF;
    tick(); tick(); tick(); tick();
    exp_cnt = exp_cnt + 1;
    settle();
    if (InstrCount_o !== 32'h0 || exp_cnt !== 32'h0) begin
      errors++; $display("FAIL count_wrap got=%h want=00000000", InstrCount_o);
    end
    tick(); tick(); tick(); tick();
    settle();
    if (InstrCount_o !== 32'h1) begin
      errors++; $display("FAIL count_after_wrap got=%h want=00000001", InstrCount_o);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_itype();
    test_branch();
    test_load_store();
    test_jal();
    test_trap();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
